midi_tx_scheduler: RTL and testbench
====================================

# midi_tx_scheduler

Round-robin scheduler that shares the single MIDI UART transmitter between several message sources (panel controls, note echo, clock/realtime generator). It latches one complete 1–3 byte MIDI message per grant and feeds it byte-by-byte into the UART's `midi_send_byte` / `midi_out_data` / `midi_out_ready` handshake. It optionally applies running-status compression. The block sits between the synthesizer control logic and the MIDI UART, in the CLOCK_25 domain.

## Interface
- `NUM_REQ`, 3: number of requesters, 2..8.
- `RUNNING_STATUS`, 1: 1 = suppress a repeated channel status byte; 0 = always send status.
- `BUSY_TIMEOUT`, 1023: cycles to wait for `midi_out_ready` to fall after a send pulse before aborting.

- `CLOCK_25`  in  1  system clock, 25 MHz.
- `reset_reg`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester message pending; level, held until `grant` bit.
- `msg_data`  in  24*NUM_REQ  per requester {status[23:16], data1[15:8], data2[7:0]}; sampled on grant.
- `msg_len`  in  2*NUM_REQ  per requester byte count 0..3; sampled on grant.
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse: message latched, requester may drop/change `req`.
- `midi_send_byte`  out  1  one-cycle pulse to UART: start one byte.
- `midi_out_data`  out  8  byte to UART; stable from the pulse until `midi_out_ready` returns high.
- `midi_out_ready`  in  1  UART idle (high) / transmitting (low).
- `busy`  out  1  high from grant until the last byte completes or aborts.
- `tx_err`  out  1  one-cycle pulse on busy-timeout abort.

## Operation
- States: IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE, NEXT.
- IDLE: if any `req` bit is set and `midi_out_ready` is high, select the first set bit at or after `rr_ptr`, searching upward with wrap. Go to LOAD.
- LOAD: pulse `grant[sel]`. Latch the 24-bit message into `buf` and the length into `len`. Set `rr_ptr` = sel+1, wrapping to 0 past NUM_REQ-1.
  - len == 0: drop the message and return to IDLE.
  - Otherwise set byte index `idx` = 0 and apply running status:
    - Condition: RUNNING_STATUS=1, status in 0x80..0xEF, and status == `last_status`.
    - Action: set `idx` = 1. If len == 1 there is nothing to send; return to IDLE.
- SEND: drive `midi_out_data` = buf byte[idx], pulse `midi_send_byte` for one cycle, clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - `midi_out_ready` low: go to WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT: pulse `tx_err`, abort the rest of the message, clear `last_status`, return to IDLE.
- WAIT_DONE: on `midi_out_ready` high, go to NEXT.
- NEXT:
  - If the byte just sent was idx 0, update `last_status`:
    - 0x80..0xEF: store the byte.
    - 0xF0..0xF7: clear to 0x00.
    - 0xF8..0xFF (realtime): leave unchanged.
  - Then idx+1 < len: increment `idx`, go to SEND. Otherwise return to IDLE.
- Data bytes are sent verbatim; the block does not validate bit 7.
- Simultaneous requests are served strictly round-robin. A `req` that drops before its grant is ignored.
- Reset mid-message: the state machine returns to IDLE immediately and the current UART byte is not waited for. The next arbitration still requires `midi_out_ready` high.

## Timing
- Reset values:
  - `grant` = 0, `midi_send_byte` = 0, `midi_out_data` = 0x00, `busy` = 0, `tx_err` = 0.
  - `rr_ptr` = 0, `last_status` = 0x00, state = IDLE.
- `req` high in IDLE at cycle N gives `grant` at N+1 (LOAD) and `midi_send_byte` at N+2.
- `busy` rises with `grant`. It falls on the cycle state returns to IDLE: after NEXT, on the abort cycle, or on a len==0 / fully suppressed LOAD.
- Between bytes of one message: NEXT→SEND adds 2 cycles after `midi_out_ready` rises.
- `midi_out_data` changes only in SEND.
- `tx_err` pulses on the cycle the timeout counter equals BUSY_TIMEOUT. The counter is 10 bits wide and saturates.
- Minimum idle gap between messages: 1 cycle in IDLE.

## Test plan
- Single note-on:
  - Stimulus: req[0] with {0x90,0x3C,0x64}, len 3; UART model drops ready 400 cycles after each pulse and raises it 8000 cycles later.
  - Required: `grant` = 001 once; bytes 0x90, 0x3C, 0x64 in order; `busy` low after the third ready rise.
- Running status:
  - Stimulus: req[1] sends {0x90,0x40,0x7F}, then {0x90,0x40,0x00}.
  - Required: the second message emits only 0x40, 0x00. Repeat with RUNNING_STATUS=0: 0x90 is re-sent.
- Status invalidation:
  - Stimulus: {0x90,..} len 3, then 0xF8 len 1, then {0x90,..}.
  - Required: third message omits 0x90 (realtime does not clear). Replace 0xF8 with 0xF6: third message re-sends 0x90.
- Round-robin fairness:
  - Stimulus: req = 111 held continuously, each message len 2.
  - Required: grant sequence 001, 010, 100, 001. No requester is granted twice in a row while others wait.
- Timeout abort:
  - Stimulus: UART model never drops ready.
  - Required: `tx_err` pulses exactly 1023 cycles after the `midi_send_byte` pulse; remaining bytes are skipped; `last_status` reads 0x00; next message re-sends status.
- Edge lengths and reset:
  - Stimulus: len 0, then reset_reg asserted while in WAIT_DONE of the second byte.
  - Required: len 0 gives `grant` with no `midi_send_byte`. After reset, all outputs hold reset values and the next `req` is arbitrated from `rr_ptr` = 0.

Source files
------------

// File: rtl/midi_tx_scheduler.sv
// midi_tx_scheduler
// Round-robin scheduler sharing one MIDI UART transmitter between several
// message sources. One complete 1..3 byte message is latched per grant and
// handed to the UART byte by byte, with optional running-status compression.
//
// Ports:
//   CLOCK_25        system clock (25 MHz)
//   reset_reg       synchronous active-high reset
//   req             per-requester message pending (level)
//   msg_data        per-requester {status, data1, data2}, 24 bits each
//   msg_len         per-requester byte count 0..3, 2 bits each
//   grant           one-hot pulse: message latched
//   midi_send_byte  one-cycle pulse to UART: start one byte
//   midi_out_data   byte to UART, held until the next send
//   midi_out_ready  UART idle (high) / transmitting (low)
//   busy            high from grant until the message completes or aborts
//   tx_err          one-cycle pulse when the UART never went busy
module midi_tx_scheduler #(
  parameter int NUM_REQ        = 3,
  parameter int RUNNING_STATUS = 1,
  parameter int BUSY_TIMEOUT   = 1023
) (
  input  logic                    CLOCK_25,
  input  logic                    reset_reg,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [24*NUM_REQ-1:0]   msg_data,
  input  logic [2*NUM_REQ-1:0]    msg_len,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    midi_send_byte,
  output logic [7:0]              midi_out_data,
  input  logic                    midi_out_ready,
  output logic                    busy,
  output logic                    tx_err
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // r_cnt is cleared in SEND, so it lags the cycles elapsed since the
  // send pulse by one; abort when the elapsed count reaches BUSY_TIMEOUT.
  localparam logic [9:0] TO_LAST = 10'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_BUSY, S_WAIT_DONE, S_NEXT
  } state_t;

  state_t           r_state, w_next;
  logic [SEL_W-1:0] r_sel, r_rr_ptr, w_sel;
  logic             w_found;
  logic [23:0]      r_buf;
  logic [1:0]       r_len, r_idx;
  logic [7:0]       r_last_status;
  logic [7:0]       r_out_hold;
  logic [9:0]       r_cnt;

  logic [23:0]      w_msg;
  logic [1:0]       w_len;
  logic [7:0]       w_status;
  logic             w_suppress;
  logic [7:0]       w_cur_byte;
  logic             w_timeout;
  logic             w_more;

  // Round-robin search: first set req bit at or after r_rr_ptr, with wrap.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_sel   = SEL_W'(j);
      end
    end
  end

  always_comb begin
    w_msg      = msg_data[int'(r_sel)*24 +: 24];
    w_len      = msg_len[int'(r_sel)*2 +: 2];
    w_status   = w_msg[23:16];
    w_suppress = (RUNNING_STATUS != 0) && (w_status >= 8'h80) &&
                 (w_status <= 8'hEF) && (w_status == r_last_status);
    case (r_idx)
      2'd0:    w_cur_byte = r_buf[23:16];
      2'd1:    w_cur_byte = r_buf[15:8];
      default: w_cur_byte = r_buf[7:0];
    endcase
    w_timeout = midi_out_ready && (r_cnt == TO_LAST);
    w_more    = (({1'b0, r_idx} + 3'd1) < {1'b0, r_len});
  end

  // State register
  always_ff @(posedge CLOCK_25) begin
    if (reset_reg) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_found && midi_out_ready) w_next = S_LOAD;
      S_LOAD:      if ((w_len == 2'd0) || (w_suppress && (w_len == 2'd1)))
                     w_next = S_IDLE;
                   else
                     w_next = S_SEND;
      S_SEND:      w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!midi_out_ready) w_next = S_WAIT_DONE;
                   else if (w_timeout)  w_next = S_IDLE;
      S_WAIT_DONE: if (midi_out_ready) w_next = S_NEXT;
      S_NEXT:      w_next = w_more ? S_SEND : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    grant = '0;
    if (r_state == S_LOAD) grant[r_sel] = 1'b1;
    midi_send_byte = (r_state == S_SEND);
    // The UART sees the new byte in the pulse cycle; the hold register keeps it after.
    midi_out_data  = (r_state == S_SEND) ? w_cur_byte : r_out_hold;
    busy           = (r_state != S_IDLE);
    tx_err         = (r_state == S_WAIT_BUSY) && w_timeout;
  end

  // Control registers that carry reset values
  always_ff @(posedge CLOCK_25) begin
    if (reset_reg) begin
      r_rr_ptr      <= '0;
      r_last_status <= 8'h00;
      r_out_hold    <= 8'h00;
    end else begin
      case (r_state)
        S_LOAD: r_rr_ptr <= (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
        S_SEND: r_out_hold <= w_cur_byte;
        S_WAIT_BUSY: if (w_timeout) r_last_status <= 8'h00;
        S_NEXT: if (r_idx == 2'd0) begin
                  // Channel status is remembered, system common cancels it,
                  // realtime bytes may interleave without disturbing it.
                  if ((r_buf[23:16] >= 8'h80) && (r_buf[23:16] <= 8'hEF))
                    r_last_status <= r_buf[23:16];
                  else if ((r_buf[23:16] >= 8'hF0) && (r_buf[23:16] <= 8'hF7))
                    r_last_status <= 8'h00;
                end
        default: ;
      endcase
    end
  end

  // Message buffer, byte index and timeout counter
  always_ff @(posedge CLOCK_25) begin
    case (r_state)
      S_IDLE: r_sel <= w_sel;
      S_LOAD: begin
        r_buf <= w_msg;
        r_len <= w_len;
        r_idx <= w_suppress ? 2'd1 : 2'd0;
      end
      S_SEND: r_cnt <= '0;
      S_WAIT_BUSY: if (r_cnt != 10'h3FF) r_cnt <= r_cnt + 10'd1;
      S_NEXT: if (w_more) r_idx <= r_idx + 2'd1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_midi_tx_scheduler.sv
module tb_midi_tx_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0: running status on; index 1: running status off.
  logic [1:0][2:0]  req_v = '0;
  logic [1:0][71:0] msg_v = '0;
  logic [1:0][5:0]  len_v = '0;
  logic [1:0]       rdy   = 2'b11;
  wire  [1:0][2:0]  grant_v;
  wire  [1:0]       send_v;
  wire  [1:0][7:0]  data_o;
  wire  [1:0]       busy_v;
  wire  [1:0]       err_v;

  midi_tx_scheduler #(.NUM_REQ(3), .RUNNING_STATUS(1), .BUSY_TIMEOUT(1023)) dut0 (
    .CLOCK_25(clk), .reset_reg(rst), .req(req_v[0]), .msg_data(msg_v[0]),
    .msg_len(len_v[0]), .grant(grant_v[0]), .midi_send_byte(send_v[0]),
    .midi_out_data(data_o[0]), .midi_out_ready(rdy[0]), .busy(busy_v[0]),
    .tx_err(err_v[0]));

  midi_tx_scheduler #(.NUM_REQ(3), .RUNNING_STATUS(0), .BUSY_TIMEOUT(1023)) dut1 (
    .CLOCK_25(clk), .reset_reg(rst), .req(req_v[1]), .msg_data(msg_v[1]),
    .msg_len(len_v[1]), .grant(grant_v[1]), .midi_send_byte(send_v[1]),
    .midi_out_data(data_o[1]), .midi_out_ready(rdy[1]), .busy(busy_v[1]),
    .tx_err(err_v[1]));

  // UART model and event log
  int         cyc = 0;
  int         drop_dly = 3;
  int         hi_dly = 6;
  logic [1:0] never_drop = 2'b00;
  int         m_cnt [2] = '{0, 0};
  int         m_ph [2] = '{0, 0};
  logic [7:0] cap_mem [2][128];
  int         cap_n [2] = '{0, 0};
  logic [2:0] gseq [2][64];
  int         gn [2] = '{0, 0};
  int         err_n [2] = '{0, 0};
  int         err_cyc [2] = '{0, 0};
  int         send_cyc [2] = '{0, 0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (grant_v[g] != 3'b000 && gn[g] < 64) begin
        gseq[g][gn[g]] <= grant_v[g];
        gn[g] <= gn[g] + 1;
      end
      if (err_v[g]) begin
        err_n[g] <= err_n[g] + 1;
        err_cyc[g] <= cyc;
      end
      if (send_v[g]) begin
        if (cap_n[g] < 128) cap_mem[g][cap_n[g]] <= data_o[g];
        cap_n[g] <= cap_n[g] + 1;
        send_cyc[g] <= cyc;
        m_cnt[g] <= 1;
        m_ph[g] <= 1;
      end else if (m_ph[g] == 1 && !never_drop[g]) begin
        if (m_cnt[g] >= drop_dly) begin
          rdy[g] <= 1'b0; m_ph[g] <= 2; m_cnt[g] <= 1;
        end else m_cnt[g] <= m_cnt[g] + 1;
      end else if (m_ph[g] == 2) begin
        if (m_cnt[g] >= hi_dly) begin
          rdy[g] <= 1'b1; m_ph[g] <= 0;
        end else m_cnt[g] <= m_cnt[g] + 1;
      end
    end
  end

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one message on requester r, wait for its grant, release req.
  task automatic run_msg(input int u, input int r, input logic [23:0] m,
                         input logic [1:0] l, input bit wait_done,
                         output int base, output int glat, output logic snd,
                         output int dur);
    int k;
    base = cap_n[u];
    dur  = 0;
    @(negedge clk);
    msg_v[u][r*24 +: 24] = m;
    len_v[u][r*2 +: 2]   = l;
    req_v[u][r]          = 1'b1;
    for (k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (grant_v[u][r]) break;
    end
    req_v[u][r] = 1'b0;
    chk("grant_wait", 32'(k < 20000), 1);
    glat = k + 1;
    @(negedge clk);
    snd = send_v[u];
    if (wait_done) begin
      for (k = 0; k < 40000; k++) begin
        if (!busy_v[u]) break;
        @(negedge clk);
      end
      chk("busy_wait", 32'(k < 40000), 1);
      dur = k;
    end
  endtask

  task automatic chk_bytes(input string tag, input int u, input int base,
                           input int n, input logic [23:0] exp);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(cap_mem[u][base + i]), 32'(exp[23 - 8*i -: 8]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, gl, du, g0, k;
    logic sn;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant_v[0]), 0);
    chk("rst_send", 32'(send_v[0]), 0);
    chk("rst_data", 32'(data_o[0]), 0);
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_err", 32'(err_v[0]), 0);
    rst = 1'b0;

    // Single note-on with slow UART
    drop_dly = 400; hi_dly = 8000;
    g0 = gn[0];
    run_msg(0, 0, 24'h903C64, 2'd3, 1'b1, b, gl, sn, du);
    chk("t1_lat_grant", 32'(gl), 1);
    chk("t1_lat_send", 32'(sn), 1);
    chk("t1_ngrant", 32'(gn[0] - g0), 1);
    chk("t1_gnt", 32'(gseq[0][g0]), 3'b001);
    chk("t1_n", 32'(cap_n[0] - b), 3);
    chk_bytes("t1", 0, b, 3, 24'h903C64);
    chk("t1_dur", 32'(du > 24000), 1);
    chk("t1_rdy", 32'(rdy[0]), 1);

    drop_dly = 3; hi_dly = 6;
    // F6 clears last status
    run_msg(0, 1, 24'hF60000, 2'd1, 1'b1, b, gl, sn, du);
    chk("b_n", 32'(cap_n[0] - b), 1);
    chk_bytes("b", 0, b, 1, 24'hF60000);
    // Running status
    run_msg(0, 1, 24'h90407F, 2'd3, 1'b1, b, gl, sn, du);
    chk("c_n", 32'(cap_n[0] - b), 3);
    chk_bytes("c", 0, b, 3, 24'h90407F);
    run_msg(0, 1, 24'h904000, 2'd3, 1'b1, b, gl, sn, du);
    chk("d_n", 32'(cap_n[0] - b), 2);
    chk_bytes("d", 0, b, 2, 24'h400000);
    // Realtime keeps last status
    run_msg(0, 2, 24'hF80000, 2'd1, 1'b1, b, gl, sn, du);
    chk_bytes("e", 0, b, 1, 24'hF80000);
    run_msg(0, 0, 24'h901122, 2'd3, 1'b1, b, gl, sn, du);
    chk("f_n", 32'(cap_n[0] - b), 2);
    chk_bytes("f", 0, b, 2, 24'h112200);
    // System common cancels it
    run_msg(0, 1, 24'hF60000, 2'd1, 1'b1, b, gl, sn, du);
    run_msg(0, 1, 24'h903344, 2'd3, 1'b1, b, gl, sn, du);
    chk("h_n", 32'(cap_n[0] - b), 3);
    chk_bytes("h", 0, b, 3, 24'h903344);

    // len 0: grant only
    g0 = gn[0];
    run_msg(0, 2, 24'h900000, 2'd0, 1'b1, b, gl, sn, du);
    chk("len0_gnt", 32'(gseq[0][g0]), 3'b100);
    chk("len0_send", 32'(sn), 0);
    chk("len0_n", 32'(cap_n[0] - b), 0);
    // len 1 fully suppressed by running status
    run_msg(0, 0, 24'h900000, 2'd1, 1'b1, b, gl, sn, du);
    chk("sup1_send", 32'(sn), 0);
    chk("sup1_n", 32'(cap_n[0] - b), 0);

    // Reset while waiting for the second byte to finish
    hi_dly = 50;
    run_msg(0, 1, 24'h90AABB, 2'd3, 1'b0, b, gl, sn, du);
    for (k = 0; k < 2000; k++) begin
      if (cap_n[0] >= b + 2) break;
      @(negedge clk);
    end
    chk("k_two_bytes", 32'(k < 2000), 1);
    repeat (8) @(negedge clk);
    chk("k_pre_busy", 32'(busy_v[0]), 1);
    chk("k_pre_rdy", 32'(rdy[0]), 0);
    chk("k_pre_data", 32'(data_o[0]), 8'hBB);
    rst = 1'b1;
    @(negedge clk);
    chk("k_rst_grant", 32'(grant_v[0]), 0);
    chk("k_rst_send", 32'(send_v[0]), 0);
    chk("k_rst_data", 32'(data_o[0]), 0);
    chk("k_rst_busy", 32'(busy_v[0]), 0);
    chk("k_rst_err", 32'(err_v[0]), 0);
    rst = 1'b0;
    hi_dly = 6;

    // Round robin with all three requesting, starting from pointer 0
    @(negedge clk);
    msg_v[0] = {24'hC20700, 24'hC10600, 24'hC00500};
    len_v[0] = {2'd2, 2'd2, 2'd2};
    g0 = gn[0];
    b  = cap_n[0];
    req_v[0] = 3'b111;
    for (k = 0; k < 40000; k++) begin
      @(negedge clk);
      if (gn[0] - g0 >= 4) break;
    end
    req_v[0] = 3'b000;
    chk("rr_wait", 32'(k < 40000), 1);
    for (k = 0; k < 40000; k++) begin
      if (!busy_v[0]) break;
      @(negedge clk);
    end
    chk("rr_g0", 32'(gseq[0][g0]), 3'b001);
    chk("rr_g1", 32'(gseq[0][g0 + 1]), 3'b010);
    chk("rr_g2", 32'(gseq[0][g0 + 2]), 3'b100);
    chk("rr_g3", 32'(gseq[0][g0 + 3]), 3'b001);
    chk("rr_n", 32'(cap_n[0] - b), 8);
    chk_bytes("rr_m0", 0, b, 2, 24'hC00500);
    chk_bytes("rr_m1", 0, b + 2, 2, 24'hC10600);
    chk_bytes("rr_m2", 0, b + 4, 2, 24'hC20700);
    chk_bytes("rr_m3", 0, b + 6, 2, 24'hC00500);

    // Timeout: UART never goes busy
    never_drop[0] = 1'b1;
    g0 = err_n[0];
    run_msg(0, 0, 24'h905566, 2'd3, 1'b1, b, gl, sn, du);
    never_drop[0] = 1'b0;
    chk("to_errs", 32'(err_n[0] - g0), 1);
    chk("to_delay", 32'(err_cyc[0] - send_cyc[0]), 1023);
    chk("to_n", 32'(cap_n[0] - b), 1);
    chk_bytes("to", 0, b, 1, 24'h900000);
    chk("to_last", 32'(dut0.r_last_status), 0);
    run_msg(0, 0, 24'h905758, 2'd3, 1'b1, b, gl, sn, du);
    chk("to_next_n", 32'(cap_n[0] - b), 3);
    chk_bytes("to_next", 0, b, 3, 24'h905758);

    // Running status disabled: status always re-sent
    run_msg(1, 1, 24'h90407F, 2'd3, 1'b1, b, gl, sn, du);
    chk("nors1_n", 32'(cap_n[1] - b), 3);
    chk_bytes("nors1", 1, b, 3, 24'h90407F);
    run_msg(1, 1, 24'h904000, 2'd3, 1'b1, b, gl, sn, du);
    chk("nors2_n", 32'(cap_n[1] - b), 3);
    chk_bytes("nors2", 1, b, 3, 24'h904000);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
